// File: rtl/dma_ctrl_axil_master.sv
// -----------------------------------------------------------------------------
// dma_ctrl_axil_master
//
// AXI4-Lite master that programs one DMA job into the DMA IP control slave:
// it writes the five job registers (0x10..0x20), writes ap_start to 0x00, then
// polls 0x00 until ap_done (bit 1) reads as 1. A one-cycle done_valid pulse
// reports the outcome (OK, write error, read error or poll timeout) together
// with the number of status reads issued.
//
// Ports
//   ACLK, ARESET             clock, synchronous active-high reset
//   cmd_valid / cmd_ready    job request handshake (ready only while idle)
//   cmd_*                    five job words, captured on the command handshake
//   busy                     high whenever a job is in progress
//   done_valid               one-cycle completion pulse
//   done_status              00 OK, 01 BRESP error, 10 RRESP error, 11 timeout
//   done_polls               status reads issued (saturating at 16'hFFFF)
//   M_AW*/M_W*/M_B*          AXI4-Lite write address/data/response channels
//   M_AR*/M_R*               AXI4-Lite read address/data channels
// -----------------------------------------------------------------------------
module dma_ctrl_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int POLL_INTERVAL      = 16,
  parameter int POLL_LIMIT         = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,

  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [31:0]                     cmd_rdma_transfer_byte,
  input  logic [31:0]                     cmd_rdma_mem_ptr,
  input  logic [31:0]                     cmd_wdma_transfer_byte,
  input  logic [31:0]                     cmd_wdma_mem_ptr,
  input  logic [31:0]                     cmd_axi00_ptr0,

  output logic                            busy,
  output logic                            done_valid,
  output logic [1:0]                      done_status,
  output logic [15:0]                     done_polls,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AWADDR,
  output logic                            M_AWVALID,
  input  logic                            M_AWREADY,

  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                            M_WVALID,
  input  logic                            M_WREADY,

  input  logic [1:0]                      M_BRESP,
  input  logic                            M_BVALID,
  output logic                            M_BREADY,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_ARADDR,
  output logic                            M_ARVALID,
  input  logic                            M_ARREADY,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]                      M_RRESP,
  input  logic                            M_RVALID,
  output logic                            M_RREADY
);

  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam int WCW = $clog2(POLL_INTERVAL + 1);

  localparam logic [AW-1:0] ADDR_CTRL      = AW'(32'h00);
  localparam logic [AW-1:0] ADDR_RDMA_LEN  = AW'(32'h10);
  localparam logic [AW-1:0] ADDR_RDMA_PTR  = AW'(32'h14);
  localparam logic [AW-1:0] ADDR_WDMA_LEN  = AW'(32'h18);
  localparam logic [AW-1:0] ADDR_WDMA_PTR  = AW'(32'h1C);
  localparam logic [AW-1:0] ADDR_AXI00_PTR = AW'(32'h20);

  localparam logic [2:0] LAST_WR_IDX = 3'd5;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BRESP   = 2'b01;
  localparam logic [1:0] ST_RRESP   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_POLL_AR,
    S_POLL_R,
    S_POLL_WAIT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]    job_rdma_len;
  logic [31:0]    job_rdma_ptr;
  logic [31:0]    job_wdma_len;
  logic [31:0]    job_wdma_ptr;
  logic [31:0]    job_axi00_ptr;

  logic [2:0]     wr_idx;
  logic           aw_done;
  logic           w_done;
  logic [PCW-1:0] poll_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [1:0]     status_q;

  logic           aw_hs;
  logic           w_hs;
  logic           wr_both_done;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [31:0]    polls_ext;
  logic [15:0]    polls_sat;

  // Only ap_done is interpreted; the remaining status bits are ignored.
  logic           unused_rdata;
  assign unused_rdata = ^{M_RDATA[DW-1:2], M_RDATA[0]};

  assign aw_hs        = M_AWVALID & M_AWREADY;
  assign w_hs         = M_WVALID & M_WREADY;
  assign wr_both_done = (aw_done | aw_hs) & (w_done | w_hs);

  // Write index -> register address / data; index 5 is the ap_start write.
  always_comb begin
    wr_addr = ADDR_CTRL;
    wr_data = DW'(32'h1);
    case (wr_idx)
      3'd0: begin wr_addr = ADDR_RDMA_LEN;  wr_data = job_rdma_len;  end
      3'd1: begin wr_addr = ADDR_RDMA_PTR;  wr_data = job_rdma_ptr;  end
      3'd2: begin wr_addr = ADDR_WDMA_LEN;  wr_data = job_wdma_len;  end
      3'd3: begin wr_addr = ADDR_WDMA_PTR;  wr_data = job_wdma_ptr;  end
      3'd4: begin wr_addr = ADDR_AXI00_PTR; wr_data = job_axi00_ptr; end
      default: begin wr_addr = ADDR_CTRL;   wr_data = DW'(32'h1);    end
    endcase
  end

  assign polls_ext = 32'(poll_cnt);
  assign polls_sat = (polls_ext > 32'h0000_FFFF) ? 16'hFFFF : polls_ext[15:0];

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_next = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (wr_both_done) state_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (M_BVALID) begin
          if (M_BRESP != 2'b00)          state_next = S_DONE;
          else if (wr_idx == LAST_WR_IDX) state_next = S_POLL_AR;
          else                            state_next = S_WR_REQ;
        end
      end
      S_POLL_AR: begin
        if (M_ARREADY) state_next = S_POLL_R;
      end
      S_POLL_R: begin
        if (M_RVALID) begin
          if (M_RRESP != 2'b00)                  state_next = S_DONE;
          else if (M_RDATA[1])                   state_next = S_DONE;
          else if (poll_cnt == PCW'(POLL_LIMIT)) state_next = S_DONE;
          else                                   state_next = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: begin
        // The countdown is loaded with POLL_INTERVAL, so this state lasts
        // exactly POLL_INTERVAL cycles.
        if (wait_cnt <= WCW'(1)) state_next = S_POLL_AR;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      job_rdma_len  <= '0;
      job_rdma_ptr  <= '0;
      job_wdma_len  <= '0;
      job_wdma_ptr  <= '0;
      job_axi00_ptr <= '0;
      wr_idx        <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      poll_cnt      <= '0;
      wait_cnt      <= '0;
      status_q      <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            job_rdma_len  <= cmd_rdma_transfer_byte;
            job_rdma_ptr  <= cmd_rdma_mem_ptr;
            job_wdma_len  <= cmd_wdma_transfer_byte;
            job_wdma_ptr  <= cmd_wdma_mem_ptr;
            job_axi00_ptr <= cmd_axi00_ptr0;
            wr_idx        <= '0;
            poll_cnt      <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            status_q      <= ST_OK;
          end
        end
        S_WR_REQ: begin
          // Per-channel completion flags let AW and W finish in either order.
          if (wr_both_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (M_BVALID) begin
            if (M_BRESP != 2'b00)          status_q <= ST_BRESP;
            else if (wr_idx != LAST_WR_IDX) wr_idx  <= wr_idx + 3'd1;
          end
        end
        S_POLL_AR: begin
          if (M_ARREADY) poll_cnt <= poll_cnt + PCW'(1);
        end
        S_POLL_R: begin
          if (M_RVALID) begin
            if (M_RRESP != 2'b00)                  status_q <= ST_RRESP;
            else if (M_RDATA[1])                   status_q <= ST_OK;
            else if (poll_cnt == PCW'(POLL_LIMIT)) status_q <= ST_TIMEOUT;
            wait_cnt <= WCW'(POLL_INTERVAL);
          end
        end
        S_POLL_WAIT: begin
          wait_cnt <= wait_cnt - WCW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    cmd_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    done_valid  = (state == S_DONE);
    done_status = (state == S_DONE) ? status_q  : 2'b00;
    done_polls  = (state == S_DONE) ? polls_sat : 16'h0000;

    M_AWVALID   = (state == S_WR_REQ) && !aw_done;
    M_AWADDR    = (state == S_WR_REQ) ? wr_addr : '0;
    M_WVALID    = (state == S_WR_REQ) && !w_done;
    M_WDATA     = (state == S_WR_REQ) ? wr_data : '0;
    M_WSTRB     = '1;
    M_BREADY    = (state == S_WR_RESP);

    M_ARVALID   = (state == S_POLL_AR);
    M_ARADDR    = '0;
    M_RREADY    = (state == S_POLL_R);
  end

endmodule

// File: tb/tb_dma_ctrl_axil_master.sv
module tb_dma_ctrl_axil_master;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int PI = 16;
  localparam int PL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic          cmd_valid, cmd_ready;
  logic [31:0]   cmd_w0, cmd_w1, cmd_w2, cmd_w3, cmd_w4;
  logic          busy, done_valid;
  logic [1:0]    done_status;
  logic [15:0]   done_polls;
  logic [AW-1:0] M_AWADDR, M_ARADDR;
  logic          M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic [DW-1:0] M_WDATA, M_RDATA;
  logic [3:0]    M_WSTRB;
  logic [1:0]    M_BRESP, M_RRESP;
  logic          M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  dma_ctrl_axil_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .POLL_INTERVAL(PI),
    .POLL_LIMIT(PL)
  ) dut (
    .ACLK(clk), .ARESET(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rdma_transfer_byte(cmd_w0), .cmd_rdma_mem_ptr(cmd_w1),
    .cmd_wdma_transfer_byte(cmd_w2), .cmd_wdma_mem_ptr(cmd_w3),
    .cmd_axi00_ptr0(cmd_w4),
    .busy(busy), .done_valid(done_valid), .done_status(done_status), .done_polls(done_polls),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  int compared = 0;
  int mismatched = 0;

  // Responder configuration
  int aw_dly_cfg[6];
  int w_dly_cfg[6];
  int berr_idx, rerr_on, done_on;

  // Responder state and logs
  int aw_wait, w_wait;
  bit got_aw, got_w, b_pend, r_pend;
  logic [1:0]  b_resp_q, r_resp_q;
  logic [31:0] r_data_q;
  logic [AW-1:0] aw_log[16];
  logic [31:0]   w_log[16];
  logic [3:0]    s_log[16];
  int aw_cyc[16], w_cyc[16], gap_log[16];
  int aw_count, w_count, wr_count, b_count, rd_count, done_cnt, proto_err, gap_count;
  int cyc = 0;
  int r_hs_cyc;
  bit r_hs_seen;
  logic [1:0]  last_status;
  logic [15:0] last_polls;
  bit prev_aw_hs, prev_w_hs, prev_awv, prev_wv, prev_arv;
  logic [AW-1:0] prev_awaddr;
  logic [31:0]   prev_wdata;

  logic [AW-1:0] exp_addr[6];
  logic [31:0]   exp_data[6];

  // Slave model: drives ready/response signals mid-cycle, then logs the
  // handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    int widx;
    cyc++;
    widx = (wr_count < 6) ? wr_count : 5;
    M_AWREADY = M_AWVALID && (aw_wait >= aw_dly_cfg[widx]);
    M_WREADY  = M_WVALID && (w_wait >= w_dly_cfg[widx]);
    M_BVALID  = b_pend;
    M_BRESP   = b_pend ? b_resp_q : 2'b00;
    M_ARREADY = M_ARVALID;
    M_RVALID  = r_pend;
    M_RDATA   = r_pend ? r_data_q : 32'h0;
    M_RRESP   = r_pend ? r_resp_q : 2'b00;

    if (!areset) begin
      if (prev_awv && !prev_aw_hs && (!M_AWVALID || M_AWADDR != prev_awaddr)) proto_err++;
      if (prev_wv && !prev_w_hs && (!M_WVALID || M_WDATA != prev_wdata)) proto_err++;
      if (prev_aw_hs && M_AWVALID) proto_err++;
      if (prev_w_hs && M_WVALID) proto_err++;
      if ((M_AWVALID || M_WVALID || M_BREADY) && (M_ARVALID || M_RREADY)) proto_err++;
    end
    prev_aw_hs  = M_AWVALID && M_AWREADY;
    prev_w_hs   = M_WVALID && M_WREADY;
    prev_awv    = M_AWVALID;
    prev_wv     = M_WVALID;
    prev_awaddr = M_AWADDR;
    prev_wdata  = M_WDATA;

    if (M_AWVALID) begin
      if (M_AWREADY) begin
        aw_log[aw_count % 16] = M_AWADDR;
        aw_cyc[aw_count % 16] = cyc;
        aw_count++;
        got_aw = 1'b1;
        aw_wait = 0;
      end else aw_wait++;
    end
    if (M_WVALID) begin
      if (M_WREADY) begin
        w_log[w_count % 16] = M_WDATA;
        s_log[w_count % 16] = M_WSTRB;
        w_cyc[w_count % 16] = cyc;
        w_count++;
        got_w = 1'b1;
        w_wait = 0;
      end else w_wait++;
    end
    if (M_BVALID && M_BREADY) begin
      b_pend = 1'b0;
      b_count++;
    end
    if (got_aw && got_w) begin
      got_aw = 1'b0;
      got_w = 1'b0;
      b_pend = 1'b1;
      b_resp_q = (wr_count == berr_idx) ? 2'b10 : 2'b00;
      wr_count++;
    end

    if (M_RVALID && M_RREADY) begin
      r_pend = 1'b0;
      r_hs_cyc = cyc;
      r_hs_seen = 1'b1;
    end
    if (M_ARVALID && !prev_arv && r_hs_seen) begin
      gap_log[gap_count % 16] = cyc - r_hs_cyc - 1;
      gap_count++;
    end
    prev_arv = M_ARVALID;
    if (M_ARVALID && M_ARREADY) begin
      rd_count++;
      r_pend = 1'b1;
      r_data_q = (rd_count == done_on) ? 32'h0000_0002 : 32'hFFFF_FFFD;
      r_resp_q = (rd_count == rerr_on) ? 2'b10 : 2'b00;
    end

    if (done_valid) begin
      done_cnt++;
      last_status = done_status;
      last_polls = done_polls;
    end
  end

  task automatic resp_reset();
    for (int i = 0; i < 6; i++) begin
      aw_dly_cfg[i] = 0;
      w_dly_cfg[i] = 0;
    end
    berr_idx = -1; rerr_on = -1; done_on = 1;
    aw_wait = 0; w_wait = 0;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
    b_resp_q = 2'b00; r_resp_q = 2'b00; r_data_q = 32'h0;
    aw_count = 0; w_count = 0; wr_count = 0; b_count = 0; rd_count = 0;
    done_cnt = 0; proto_err = 0; gap_count = 0; r_hs_cyc = 0; r_hs_seen = 0;
    last_status = 2'b00; last_polls = 16'h0;
    prev_aw_hs = 0; prev_w_hs = 0; prev_awv = 0; prev_wv = 0; prev_arv = 0;
    prev_awaddr = '0; prev_wdata = '0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 2'b00;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = 32'h0; M_RRESP = 2'b00;
  endtask

  task automatic send_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input logic [31:0] w4);
    cmd_w0 = w0; cmd_w1 = w1; cmd_w2 = w2; cmd_w3 = w3; cmd_w4 = w4;
    exp_addr[0] = 6'h10; exp_addr[1] = 6'h14; exp_addr[2] = 6'h18;
    exp_addr[3] = 6'h1C; exp_addr[4] = 6'h20; exp_addr[5] = 6'h00;
    exp_data[0] = w0; exp_data[1] = w1; exp_data[2] = w2;
    exp_data[3] = w3; exp_data[4] = w4; exp_data[5] = 32'h1;
    cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    compared++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin mismatched++;
      $display("FAIL reset_ready_busy: got ready=%b busy=%b expected ready=1 busy=0", cmd_ready, busy); end
    compared++; if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, done_valid} !== 6'b0) begin mismatched++;
      $display("FAIL reset_handshakes: got %b expected 000000",
               {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, done_valid}); end
    compared++; if (done_status !== 2'b00 || done_polls !== 16'h0) begin mismatched++;
      $display("FAIL reset_done_fields: got status=%b polls=%0d expected 0/0", done_status, done_polls); end
    compared++; if (M_AWADDR !== '0 || M_WDATA !== '0 || M_ARADDR !== '0) begin mismatched++;
      $display("FAIL reset_addr_data: got aw=%h w=%h ar=%h expected 0", M_AWADDR, M_WDATA, M_ARADDR); end
    areset = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_nominal();
    bit ok;
    resp_reset();
    done_on = 3;
    send_cmd(32'h100, 32'h8000_0000, 32'h100, 32'h9000_0000, 32'hA000_0000);
    compared++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin mismatched++;
      $display("FAIL nom_busy: got busy=%b ready=%b expected 1/0", busy, cmd_ready); end
    // Commands offered while busy must be ignored.
    cmd_w0 = 32'hDEAD_BEEF; cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2; cmd_valid = 1'b0;
    wait_done(600, ok);
    compared++; if (!ok) begin mismatched++;
      $display("FAIL nom_done_seen: got no done_valid expected one within budget"); end
    compared++; if (cmd_ready !== 1'b1) begin mismatched++;
      $display("FAIL nom_ready_after: got %b expected 1", cmd_ready); end
    repeat (3) @(posedge clk);
    #2;
    compared++; if (done_cnt !== 1) begin mismatched++;
      $display("FAIL nom_done_count: got %0d expected 1", done_cnt); end
    compared++; if (last_status !== 2'b00 || last_polls !== 16'd3) begin mismatched++;
      $display("FAIL nom_status_polls: got %b/%0d expected 00/3", last_status, last_polls); end
    compared++; if (wr_count !== 6 || b_count !== 6 || rd_count !== 3) begin mismatched++;
      $display("FAIL nom_counts: got wr=%0d b=%0d rd=%0d expected 6/6/3", wr_count, b_count, rd_count); end
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (aw_log[i] !== exp_addr[i] || w_log[i] !== exp_data[i] || s_log[i] !== 4'hF) begin mismatched++;
        $display("FAIL nom_write%0d: got addr=%h data=%h strb=%h expected %h/%h/f",
                 i, aw_log[i], w_log[i], s_log[i], exp_addr[i], exp_data[i]); end
    end
    compared++; if (gap_count !== 2) begin mismatched++;
      $display("FAIL nom_gap_count: got %0d expected 2", gap_count); end
    for (int i = 0; i < 2; i++) begin
      compared++; if (gap_log[i] !== PI) begin mismatched++;
        $display("FAIL nom_read_spacing%0d: got %0d expected %0d", i, gap_log[i], PI); end
    end
    compared++; if (proto_err !== 0) begin mismatched++;
      $display("FAIL nom_protocol: got %0d violations expected 0", proto_err); end
  endtask

  task automatic test_channel_skew();
    bit ok;
    resp_reset();
    aw_dly_cfg[0] = 4;
    w_dly_cfg[1] = 4;
    send_cmd(32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 32'h5555_0000);
    wait_done(600, ok);
    compared++; if (!ok) begin mismatched++;
      $display("FAIL skew_done_seen: got no done_valid expected one within budget"); end
    repeat (3) @(posedge clk);
    #2;
    compared++; if (aw_count !== 6 || w_count !== 6 || b_count !== 6) begin mismatched++;
      $display("FAIL skew_beats: got aw=%0d w=%0d b=%0d expected 6/6/6", aw_count, w_count, b_count); end
    compared++; if (aw_cyc[0] - w_cyc[0] !== 4) begin mismatched++;
      $display("FAIL skew_w_first: got AW-W=%0d expected 4", aw_cyc[0] - w_cyc[0]); end
    compared++; if (w_cyc[1] - aw_cyc[1] !== 4) begin mismatched++;
      $display("FAIL skew_aw_first: got W-AW=%0d expected 4", w_cyc[1] - aw_cyc[1]); end
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (aw_log[i] !== exp_addr[i] || w_log[i] !== exp_data[i]) begin mismatched++;
        $display("FAIL skew_write%0d: got addr=%h data=%h expected %h/%h",
                 i, aw_log[i], w_log[i], exp_addr[i], exp_data[i]); end
    end
    compared++; if (done_cnt !== 1 || last_status !== 2'b00 || last_polls !== 16'd1) begin mismatched++;
      $display("FAIL skew_done: got cnt=%0d status=%b polls=%0d expected 1/00/1", done_cnt, last_status, last_polls); end
    compared++; if (proto_err !== 0) begin mismatched++;
      $display("FAIL skew_protocol: got %0d violations expected 0", proto_err); end
  endtask

  task automatic test_write_error();
    bit ok;
    resp_reset();
    berr_idx = 2;
    send_cmd(32'h100, 32'h8000_0000, 32'h100, 32'h9000_0000, 32'hA000_0000);
    wait_done(600, ok);
    compared++; if (!ok) begin mismatched++;
      $display("FAIL werr_done_seen: got no done_valid expected one within budget"); end
    repeat (3) @(posedge clk);
    #2;
    compared++; if (wr_count !== 3 || aw_count !== 3 || rd_count !== 0) begin mismatched++;
      $display("FAIL werr_counts: got wr=%0d aw=%0d rd=%0d expected 3/3/0", wr_count, aw_count, rd_count); end
    compared++; if (aw_log[2] !== 6'h18) begin mismatched++;
      $display("FAIL werr_last_addr: got %h expected 18", aw_log[2]); end
    compared++; if (done_cnt !== 1 || last_status !== 2'b01 || last_polls !== 16'd0) begin mismatched++;
      $display("FAIL werr_done: got cnt=%0d status=%b polls=%0d expected 1/01/0", done_cnt, last_status, last_polls); end
  endtask

  task automatic test_timeout();
    bit ok;
    resp_reset();
    done_on = -1;
    send_cmd(32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
    wait_done(600, ok);
    compared++; if (!ok) begin mismatched++;
      $display("FAIL tmo_done_seen: got no done_valid expected one within budget"); end
    repeat (3) @(posedge clk);
    #2;
    compared++; if (rd_count !== PL) begin mismatched++;
      $display("FAIL tmo_reads: got %0d expected %0d", rd_count, PL); end
    compared++; if (done_cnt !== 1 || last_status !== 2'b11 || last_polls !== 16'd4) begin mismatched++;
      $display("FAIL tmo_done: got cnt=%0d status=%b polls=%0d expected 1/11/4", done_cnt, last_status, last_polls); end
    compared++; if (gap_count !== 3 || gap_log[2] !== PI) begin mismatched++;
      $display("FAIL tmo_spacing: got gaps=%0d last=%0d expected 3/%0d", gap_count, gap_log[2], PI); end
  endtask

  task automatic test_read_error();
    bit ok;
    resp_reset();
    done_on = -1;
    rerr_on = 2;
    send_cmd(32'h10, 32'h20, 32'h30, 32'h40, 32'h50);
    wait_done(600, ok);
    compared++; if (!ok) begin mismatched++;
      $display("FAIL rerr_done_seen: got no done_valid expected one within budget"); end
    repeat (3) @(posedge clk);
    #2;
    compared++; if (rd_count !== 2) begin mismatched++;
      $display("FAIL rerr_reads: got %0d expected 2", rd_count); end
    compared++; if (done_cnt !== 1 || last_status !== 2'b10 || last_polls !== 16'd2) begin mismatched++;
      $display("FAIL rerr_done: got cnt=%0d status=%b polls=%0d expected 1/10/2", done_cnt, last_status, last_polls); end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    bit found;
    resp_reset();
    aw_dly_cfg[1] = 20;
    send_cmd(32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004, 32'hAAAA_0005);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_count == 1 && M_AWVALID === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    compared++; if (!found) begin mismatched++;
      $display("FAIL mid_second_write: got no second AWVALID expected one within 50 cycles"); end
    areset = 1'b1;
    @(posedge clk); #2;
    compared++; if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY} !== 5'b0) begin mismatched++;
      $display("FAIL mid_valids_low: got %b expected 00000",
               {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}); end
    compared++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0) begin mismatched++;
      $display("FAIL mid_idle: got ready=%b busy=%b done=%b expected 1/0/0", cmd_ready, busy, done_valid); end
    resp_reset();
    areset = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    compared++; if (done_cnt !== 0 || aw_count !== 0) begin mismatched++;
      $display("FAIL mid_quiet: got done=%0d aw=%0d expected 0/0", done_cnt, aw_count); end
    send_cmd(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
    wait_done(600, ok);
    compared++; if (!ok) begin mismatched++;
      $display("FAIL mid_restart_done: got no done_valid expected one within budget"); end
    repeat (3) @(posedge clk);
    #2;
    compared++; if (aw_log[0] !== 6'h10 || w_log[0] !== 32'h11) begin mismatched++;
      $display("FAIL mid_restart_first: got addr=%h data=%h expected 10/11", aw_log[0], w_log[0]); end
    compared++; if (wr_count !== 6 || done_cnt !== 1 || last_status !== 2'b00) begin mismatched++;
      $display("FAIL mid_restart_job: got wr=%0d done=%0d status=%b expected 6/1/00", wr_count, done_cnt, last_status); end
  endtask

  initial begin
    areset = 1'b1;
    cmd_valid = 1'b0;
    cmd_w0 = '0; cmd_w1 = '0; cmd_w2 = '0; cmd_w3 = '0; cmd_w4 = '0;
    resp_reset();
    test_reset();
    test_nominal();
    test_channel_skew();
    test_write_error();
    test_timeout();
    test_read_error();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
